user_input_edge_pulser: RTL and testbench

//  Multi-channel conditioner for raw board inputs (KEY/SW). Per channel: synchroniser,

---
 rtl/user_input_edge_pulser_pkg.sv | 23 ++
 rtl/user_input_channel.sv | 144 ++++++++++++++
 rtl/user_input_edge_pulser.sv | 64 ++++++
 tb/tb_user_input_edge_pulser.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/user_input_edge_pulser_pkg.sv
// Shared definitions for the user input edge pulser.
//   - MODE_* : per-channel edge-select codes carried on the mode bus
//   - rpt_state_e : auto-repeat FSM state codes
//   - cnt_width() : counter width helper, never narrower than one bit
package user_input_edge_pulser_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'b00,
        RPT_DELAY  = 2'b01,
        RPT_REPEAT = 2'b10
    } rpt_state_e;

    // Width needed to hold 0..max_val; a zero-width counter is not legal.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/user_input_channel.sv
// One conditioned input bit: synchroniser, debounce filter, edge select and auto-repeat.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_raw    : raw asynchronous input
//   mode      : 00 off, 01 rise, 10 fall, 11 both
//   level     : debounced, registered level
//   pulse     : registered one-clock event pulse
//   pulse_c   : next-state value of pulse (used by the parent to build pulse_any)
module user_input_channel
    import user_input_edge_pulser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 2,
    parameter logic        IDLE_LEVEL    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_raw,
    input  logic [1:0] mode,
    output logic       level,
    output logic       pulse,
    output logic       pulse_c
);

    localparam int unsigned CNT_W  = cnt_width(DEBOUNCE);
    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W = cnt_width(RMAX);
    localparam bit          REPEAT_ON = (REPEAT_DELAY > 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    rpt_state_e             state_q, state_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;

    logic s;
    logic level_upd;
    logic edge_hit;
    logic rpt_hit;
    logic rpt_mode;
    logic at_active;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift, debounce filter and edge select
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], in_raw};
        level_d   = level_q;
        cnt_d     = cnt_q;
        level_upd = 1'b0;
        edge_hit  = 1'b0;

        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
            level_d   = s;
            cnt_d     = '0;
            level_upd = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Mode is only looked at on a level update, so mode changes alone are silent
        case (mode)
            MODE_RISE: edge_hit = level_upd & level_d;
            MODE_FALL: edge_hit = level_upd & ~level_d;
            MODE_BOTH: edge_hit = level_upd;
            default:   edge_hit = 1'b0;
        endcase
    end

    // Auto-repeat next state; leaving the active level wins over a due repeat pulse
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rpt_hit   = 1'b0;
        rpt_mode  = (mode == MODE_RISE) || (mode == MODE_FALL);
        at_active = (level_d == (mode == MODE_RISE));

        if (!REPEAT_ON || !rpt_mode || !at_active) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                RPT_IDLE: begin
                    if (edge_hit) begin
                        state_d = RPT_DELAY;
                        rcnt_d  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
                        state_d = RPT_REPEAT;
                        rpt_hit = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_q == RCNT_W'(REPEAT_PERIOD - 1)) begin
                        rpt_hit = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        pulse_d = edge_hit | rpt_hit;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
            level_q <= IDLE_LEVEL;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level   = level_q;
    assign pulse   = pulse_q;
    assign pulse_c = pulse_d;

endmodule

// File: rtl/user_input_edge_pulser.sv
// Multi-channel conditioner for raw board inputs (keys/switches).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in        : CH raw asynchronous inputs
//   mode      : per-channel edge select, bits [2i+1:2i]
//   level     : CH debounced, registered levels
//   pulse     : CH registered one-clock event pulses
//   pulse_any : registered OR of all channel pulses, same cycle as pulse
module user_input_edge_pulser
    import user_input_edge_pulser_pkg::*;
#(
    parameter int unsigned CH            = 2,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 2,
    parameter logic        IDLE_LEVEL    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   pulse,
    output logic            pulse_any
);

    logic [CH-1:0] pulse_c;
    logic          pulse_any_q, pulse_any_d;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        user_input_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE     (DEBOUNCE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .IDLE_LEVEL   (IDLE_LEVEL)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_raw (in[i]),
            .mode   (mode[2*i +: 2]),
            .level  (level[i]),
            .pulse  (pulse[i]),
            .pulse_c(pulse_c[i])
        );
    end

    // OR of next-state pulses so pulse_any lines up with pulse
    always_comb begin
        pulse_any_d = |pulse_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_any_q <= 1'b0;
        end else begin
            pulse_any_q <= pulse_any_d;
        end
    end

    assign pulse_any = pulse_any_q;

endmodule

// File: tb/tb_user_input_edge_pulser.sv
// Bench for user_input_edge_pulser: one instance without repeat (a), one with
// REPEAT_DELAY=4, REPEAT_PERIOD=2 (b). Expected pulses are queued with their cycle.
module tb_user_input_edge_pulser;

    typedef struct {
        int         at;
        int         dut;
        logic [1:0] p;
    } sb_entry_t;

    logic       clk;
    logic       rst;
    logic [1:0] in_a, in_b;
    logic [3:0] mode_a, mode_b;
    logic [1:0] level_a, level_b, pulse_a, pulse_b;
    logic       pany_a, pany_b;

    sb_entry_t  sb[$];
    int         cyc;
    int         n_checks;
    int         n_errors;
    int         t;

    user_input_edge_pulser #(
        .CH(2), .SYNC_STAGES(2), .DEBOUNCE(3),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(2), .IDLE_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .mode(mode_a),
        .level(level_a), .pulse(pulse_a), .pulse_any(pany_a)
    );

    user_input_edge_pulser #(
        .CH(2), .SYNC_STAGES(2), .DEBOUNCE(3),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .IDLE_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .mode(mode_b),
        .level(level_b), .pulse(pulse_b), .pulse_any(pany_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int at, input int dut, input logic [1:0] p);
        sb_entry_t e;
        e.at  = at;
        e.dut = dut;
        e.p   = p;
        sb.push_back(e);
    endtask

    // Pop everything due this cycle and compare both instances
    task automatic check_sb();
        logic [1:0] exp_a, exp_b;
        exp_a = 2'b00;
        exp_b = 2'b00;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                if (sb[i].dut == 0) exp_a = exp_a | sb[i].p;
                else                exp_b = exp_b | sb[i].p;
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                chk("sb_stale", 2'b01, 2'b00);
                sb.delete(i);
            end
        end
        chk("pulse_a", pulse_a, exp_a);
        chk("pany_a", {1'b0, pany_a}, {1'b0, |exp_a});
        chk("pulse_b", pulse_b, exp_b);
        chk("pany_b", {1'b0, pany_b}, {1'b0, |exp_b});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_sb();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b0;
        in_a     = 2'b11;
        in_b     = 2'b11;
        mode_a   = 4'b0000;
        mode_b   = 4'b0000;
        #1 rst = 1'b1;
        #1;
        chk("rst_level_a", level_a, 2'b11);
        chk("rst_level_b", level_b, 2'b11);
        chk("rst_pulse_a", pulse_a, 2'b00);
        chk("rst_pany_a", {1'b0, pany_a}, 2'b00);
        repeat (2) tick();
        rst = 1'b0;

        // 1: idle after release
        repeat (10) begin
            tick();
            chk("t1_level_a", level_a, 2'b11);
            chk("t1_level_b", level_b, 2'b11);
        end

        // 2: falling edge on ch0, latency t+5
        mode_a = 4'b0010;
        in_a   = 2'b10;
        t = cyc + 1;
        expect_pulse(t + 5, 0, 2'b01);
        repeat (5) tick();
        chk("t2_level_pre", level_a, 2'b11);
        tick();
        chk("t2_level_post", level_a, 2'b10);
        repeat (3) tick();
        chk("t2_level_hold", level_a, 2'b10);
        in_a = 2'b11;
        repeat (8) tick();
        chk("t2_level_back", level_a, 2'b11);

        // 3: 3-cycle glitch is discarded
        in_a = 2'b10;
        repeat (3) tick();
        in_a = 2'b11;
        repeat (8) tick();
        chk("t3_level", level_a, 2'b11);

        // shortest accepted low (DEBOUNCE+1 samples), also proves cnt restarted at 0
        in_a = 2'b10;
        t = cyc + 1;
        expect_pulse(t + 5, 0, 2'b01);
        repeat (4) tick();
        in_a = 2'b11;
        repeat (10) tick();
        chk("t3b_level", level_a, 2'b11);

        // 4: both-edge mode on ch1
        mode_a = 4'b1110;
        in_a   = 2'b01;
        t = cyc + 1;
        expect_pulse(t + 5, 0, 2'b10);
        repeat (10) tick();
        chk("t4_level_low", level_a, 2'b01);
        in_a = 2'b11;
        expect_pulse(t + 15, 0, 2'b10);
        repeat (10) tick();
        chk("t4_level_high", level_a, 2'b11);

        // mode change alone is silent
        mode_a = 4'b0101;
        repeat (3) tick();

        // 5: simultaneous falls
        mode_a = 4'b1010;
        in_a   = 2'b00;
        t = cyc + 1;
        expect_pulse(t + 5, 0, 2'b11);
        repeat (8) tick();
        chk("t5_level_low", level_a, 2'b00);
        in_a = 2'b11;
        repeat (8) tick();
        chk("t5_level_high", level_a, 2'b11);

        // 6: auto-repeat; release lands on a due repeat edge (t+17), which is suppressed
        mode_b = 4'b0010;
        in_b   = 2'b10;
        t = cyc + 1;
        expect_pulse(t + 5, 1, 2'b01);
        expect_pulse(t + 9, 1, 2'b01);
        expect_pulse(t + 11, 1, 2'b01);
        expect_pulse(t + 13, 1, 2'b01);
        expect_pulse(t + 15, 1, 2'b01);
        repeat (12) tick();
        in_b = 2'b11;
        repeat (12) tick();
        chk("t6_level_back", level_b, 2'b11);

        // reset mid-hold while a repeat pulse is on the output
        in_b = 2'b10;
        t = cyc + 1;
        expect_pulse(t + 5, 1, 2'b01);
        expect_pulse(t + 9, 1, 2'b01);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_pulse_b", pulse_b, 2'b00);
        chk("t6_rst_pany_b", {1'b0, pany_b}, 2'b00);
        chk("t6_rst_level_b", level_b, 2'b11);
        chk("t6_rst_level_a", level_a, 2'b11);
        repeat (2) tick();
        rst = 1'b0;

        // input still low after release is a fresh change
        t = cyc + 1;
        expect_pulse(t + 5, 1, 2'b01);
        expect_pulse(t + 9, 1, 2'b01);
        expect_pulse(t + 11, 1, 2'b01);
        expect_pulse(t + 13, 1, 2'b01);
        repeat (4) tick();
        chk("t6_post_level_pre", level_b, 2'b11);
        repeat (6) tick();
        chk("t6_post_level_low", level_b, 2'b10);
        in_b = 2'b11;
        repeat (12) tick();
        chk("t6_post_level_back", level_b, 2'b11);

        chk("sb_empty", 2'(sb.size() != 0), 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
